// File: rtl/icw_ocw_command_sequencer.sv
// 8259 command sequencer: detects write strobes from the read/write stage,
// walks the ICW1..ICW4 initialization sequence, then decodes OCW1/OCW2/OCW3.
// Holds all programmed configuration and emits one-cycle EOI command pulses.
module icw_ocw_command_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic              a0,
    input  logic [DATA_W-1:0] data_in,
    output logic              init_done,
    output logic              ltim,
    output logic              single_mode,
    output logic [4:0]        vector_base,
    output logic [DATA_W-1:0] cascade_cfg,
    output logic              auto_eoi,
    output logic [DATA_W-1:0] imr,
    output logic              eoi_pulse,
    output logic              eoi_specific,
    output logic [2:0]        eoi_level,
    output logic              rotate,
    output logic              read_isr
);

    typedef enum logic [2:0] {
        UNINIT,
        WAIT_ICW2,
        WAIT_ICW3,
        WAIT_ICW4,
        READY
    } state_t;

    state_t            state_q, state_d;
    logic              wr_prev_q;
    logic              ic4_q, ic4_d;
    logic              init_done_q, init_done_d;
    logic              ltim_q, ltim_d;
    logic              single_q, single_d;
    logic [4:0]        vbase_q, vbase_d;
    logic [DATA_W-1:0] cas_q, cas_d;
    logic              aeoi_q, aeoi_d;
    logic [DATA_W-1:0] imr_q, imr_d;
    logic              pulse_q, pulse_d;
    logic              sl_q, sl_d;
    logic [2:0]        lvl_q, lvl_d;
    logic              rot_q, rot_d;
    logic              risr_q, risr_d;

    logic wr_event;
    logic is_icw1;

    // A write happens only on the high-to-low transition of the strobe.
    assign wr_event = wr_prev_q & ~write_enable;
    assign is_icw1  = wr_event & ~a0 & data_in[4];

    // State and configuration registers; reset overrides any write event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= UNINIT;
            wr_prev_q   <= 1'b1;
            ic4_q       <= 1'b0;
            init_done_q <= 1'b0;
            ltim_q      <= 1'b0;
            single_q    <= 1'b0;
            vbase_q     <= '0;
            cas_q       <= '0;
            aeoi_q      <= 1'b0;
            imr_q       <= '0;
            pulse_q     <= 1'b0;
            sl_q        <= 1'b0;
            lvl_q       <= '0;
            rot_q       <= 1'b0;
            risr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_prev_q   <= write_enable;
            ic4_q       <= ic4_d;
            init_done_q <= init_done_d;
            ltim_q      <= ltim_d;
            single_q    <= single_d;
            vbase_q     <= vbase_d;
            cas_q       <= cas_d;
            aeoi_q      <= aeoi_d;
            imr_q       <= imr_d;
            pulse_q     <= pulse_d;
            sl_q        <= sl_d;
            lvl_q       <= lvl_d;
            rot_q       <= rot_d;
            risr_q      <= risr_d;
        end
    end

    // Next-state decode: ICW1 restarts from any state, otherwise step by state.
    always_comb begin
        state_d     = state_q;
        ic4_d       = ic4_q;
        init_done_d = init_done_q;
        ltim_d      = ltim_q;
        single_d    = single_q;
        vbase_d     = vbase_q;
        cas_d       = cas_q;
        aeoi_d      = aeoi_q;
        imr_d       = imr_q;
        pulse_d     = 1'b0;
        sl_d        = sl_q;
        lvl_d       = lvl_q;
        rot_d       = rot_q;
        risr_d      = risr_q;

        if (is_icw1) begin
            ltim_d      = data_in[3];
            single_d    = data_in[1];
            ic4_d       = data_in[0];
            imr_d       = '0;
            risr_d      = 1'b0;
            aeoi_d      = 1'b0;
            init_done_d = 1'b0;
            state_d     = WAIT_ICW2;
        end else if (wr_event) begin
            unique case (state_q)
                WAIT_ICW2: if (a0) begin
                    vbase_d = data_in[7:3];
                    if (!single_q) begin
                        state_d = WAIT_ICW3;
                    end else if (ic4_q) begin
                        state_d = WAIT_ICW4;
                    end else begin
                        state_d     = READY;
                        init_done_d = 1'b1;
                    end
                end
                WAIT_ICW3: if (a0) begin
                    cas_d = data_in;
                    if (ic4_q) begin
                        state_d = WAIT_ICW4;
                    end else begin
                        state_d     = READY;
                        init_done_d = 1'b1;
                    end
                end
                WAIT_ICW4: if (a0) begin
                    aeoi_d      = data_in[1];
                    state_d     = READY;
                    init_done_d = 1'b1;
                end
                READY: begin
                    if (a0) begin
                        imr_d = data_in;
                    end else if (!data_in[3]) begin
                        rot_d   = data_in[7];
                        sl_d    = data_in[6];
                        lvl_d   = data_in[2:0];
                        pulse_d = data_in[5];
                    end else if (data_in[1]) begin
                        risr_d = data_in[0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done    = init_done_q;
    assign ltim         = ltim_q;
    assign single_mode  = single_q;
    assign vector_base  = vbase_q;
    assign cascade_cfg  = cas_q;
    assign auto_eoi     = aeoi_q;
    assign imr          = imr_q;
    assign eoi_pulse    = pulse_q;
    assign eoi_specific = sl_q;
    assign eoi_level    = lvl_q;
    assign rotate       = rot_q;
    assign read_isr     = risr_q;

endmodule

// File: tb/tb_icw_ocw_command_sequencer.sv
// Scoreboard bench for icw_ocw_command_sequencer: a behavioural model pushes
// expected output snapshots when writes are driven; they are popped and
// compared field by field on the falling edge after the DUT updates.
module tb_icw_ocw_command_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write_enable = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] data_in = '0;
    logic       init_done, ltim, single_mode, auto_eoi;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg, imr;
    logic       eoi_pulse, eoi_specific, rotate, read_isr;
    logic [2:0] eoi_level;

    icw_ocw_command_sequencer #(.DATA_W(8)) dut (
        .clk(clk), .reset(reset), .write_enable(write_enable), .a0(a0),
        .data_in(data_in), .init_done(init_done), .ltim(ltim),
        .single_mode(single_mode), .vector_base(vector_base),
        .cascade_cfg(cascade_cfg), .auto_eoi(auto_eoi), .imr(imr),
        .eoi_pulse(eoi_pulse), .eoi_specific(eoi_specific),
        .eoi_level(eoi_level), .rotate(rotate), .read_isr(read_isr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       init_done;
        logic       ltim;
        logic       single_mode;
        logic [4:0] vector_base;
        logic [7:0] cascade_cfg;
        logic       auto_eoi;
        logic [7:0] imr;
        logic       eoi_pulse;
        logic       eoi_specific;
        logic [2:0] eoi_level;
        logic       rotate;
        logic       read_isr;
    } snap_t;

    typedef enum int {M_UNINIT, M_ICW2, M_ICW3, M_ICW4, M_READY} mstate_t;

    snap_t   m;
    mstate_t m_state;
    logic    m_ic4;
    snap_t   sb[$];
    int      total = 0;
    int      bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic snap_t dut_snap();
        snap_t s;
        s.init_done = init_done;       s.ltim = ltim;
        s.single_mode = single_mode;   s.vector_base = vector_base;
        s.cascade_cfg = cascade_cfg;   s.auto_eoi = auto_eoi;
        s.imr = imr;                   s.eoi_pulse = eoi_pulse;
        s.eoi_specific = eoi_specific; s.eoi_level = eoi_level;
        s.rotate = rotate;             s.read_isr = read_isr;
        return s;
    endfunction

    task automatic pop_compare(input string tag);
        snap_t e, g;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        g = dut_snap();
        check({tag, ".init_done"},    32'(g.init_done),    32'(e.init_done));
        check({tag, ".ltim"},         32'(g.ltim),         32'(e.ltim));
        check({tag, ".single_mode"},  32'(g.single_mode),  32'(e.single_mode));
        check({tag, ".vector_base"},  32'(g.vector_base),  32'(e.vector_base));
        check({tag, ".cascade_cfg"},  32'(g.cascade_cfg),  32'(e.cascade_cfg));
        check({tag, ".auto_eoi"},     32'(g.auto_eoi),     32'(e.auto_eoi));
        check({tag, ".imr"},          32'(g.imr),          32'(e.imr));
        check({tag, ".eoi_pulse"},    32'(g.eoi_pulse),    32'(e.eoi_pulse));
        check({tag, ".eoi_specific"}, 32'(g.eoi_specific), 32'(e.eoi_specific));
        check({tag, ".eoi_level"},    32'(g.eoi_level),    32'(e.eoi_level));
        check({tag, ".rotate"},       32'(g.rotate),       32'(e.rotate));
        check({tag, ".read_isr"},     32'(g.read_isr),     32'(e.read_isr));
    endtask

    task automatic model_reset();
        m = '0;
        m_state = M_UNINIT;
        m_ic4 = 1'b0;
    endtask

    // Behavioural reading of the command set, applied once per write event.
    task automatic model_write(input logic a, input logic [7:0] d);
        m.eoi_pulse = 1'b0;
        if (!a && d[4]) begin
            m.ltim = d[3]; m.single_mode = d[1]; m_ic4 = d[0];
            m.imr = 8'h00; m.read_isr = 1'b0; m.auto_eoi = 1'b0;
            m.init_done = 1'b0; m_state = M_ICW2;
        end else if (m_state == M_ICW2 && a) begin
            m.vector_base = d[7:3];
            m_state = !m.single_mode ? M_ICW3 : (m_ic4 ? M_ICW4 : M_READY);
        end else if (m_state == M_ICW3 && a) begin
            m.cascade_cfg = d;
            m_state = m_ic4 ? M_ICW4 : M_READY;
        end else if (m_state == M_ICW4 && a) begin
            m.auto_eoi = d[1];
            m_state = M_READY;
        end else if (m_state == M_READY) begin
            if (a) m.imr = d;
            else if (d[3:3] == 1'b0) begin
                m.rotate = d[7]; m.eoi_specific = d[6];
                m.eoi_level = d[2:0]; m.eoi_pulse = d[5];
            end else if (d[1]) m.read_isr = d[0];
        end
        if (m_state == M_READY) m.init_done = 1'b1;
    endtask

    // One strobe held low for `hold` cycles; only the first edge is an event.
    task automatic do_write(input string tag, input logic a, input logic [7:0] d,
                            input int hold = 1);
        @(negedge clk);
        write_enable = 1'b0; a0 = a; data_in = d;
        model_write(a, d);
        sb.push_back(m);
        @(negedge clk);
        pop_compare(tag);
        m.eoi_pulse = 1'b0;
        for (int i = 1; i < hold; i++) begin
            a0 = a; data_in = d;
            sb.push_back(m);
            @(negedge clk);
            pop_compare({tag, ".held"});
        end
        write_enable = 1'b1; a0 = 1'($urandom); data_in = 8'($urandom);
        sb.push_back(m);
        @(negedge clk);
        pop_compare({tag, ".after"});
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        sb.push_back(m);
        @(negedge clk);
        reset = 1'b0;
        pop_compare(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.push_back(m);
        pop_compare("reset");

        // Single mode with ICW4
        do_write("s1.icw1", 1'b0, 8'h13);
        do_write("s1.icw2", 1'b1, 8'h40);
        do_write("s1.icw4", 1'b1, 8'h02);
        check("s1.vbase_const", 32'(vector_base), 32'h08);
        check("s1.aeoi_const",  32'(auto_eoi),    32'd1);
        check("s1.init_const",  32'(init_done),   32'd1);
        check("s1.cas_const",   32'(cascade_cfg), 32'd0);

        // Cascade mode without ICW4
        do_write("s2.icw1", 1'b0, 8'h10);
        do_write("s2.icw2", 1'b1, 8'h20);
        do_write("s2.icw3", 1'b1, 8'h04);
        check("s2.cas_const",  32'(cascade_cfg), 32'h04);
        check("s2.init_const", 32'(init_done),   32'd1);

        // Operation commands
        do_write("ocw1", 1'b1, 8'hA5);
        do_write("ocw2.eoi", 1'b0, 8'h63);
        do_write("ocw2.noeoi", 1'b0, 8'hC5);
        do_write("ocw3.rr1", 1'b0, 8'h0B);
        do_write("ocw3.rr0", 1'b0, 8'h08);
        check("ocw3.hold_const", 32'(read_isr), 32'd1);
        do_write("ocw3.irr", 1'b0, 8'h0A);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            d[4] = 1'b0;
            do_write($sformatf("rnd%0d", i), 1'($urandom), d);
        end

        // Mid-sequence restart, then a long strobe
        do_write("r.icw1", 1'b0, 8'h11);
        do_write("r.icw2", 1'b1, 8'h48);
        do_write("r.restart", 1'b0, 8'h1A);
        check("r.ltim_const", 32'(ltim), 32'd1);
        check("r.init_const", 32'(init_done), 32'd0);
        do_write("r.ign_a0lo", 1'b0, 8'h07);
        do_write("r.hold5", 1'b1, 8'h28, 5);
        check("r.imr_const", 32'(imr), 32'd0);

        // Pre-init writes ignored
        apply_reset("reset2");
        do_write("pre.a0hi", 1'b1, 8'hFF);
        do_write("pre.a0lo", 1'b0, 8'h0B);

        // Reset overriding a write in WAIT_ICW3
        do_write("w3.icw1", 1'b0, 8'h1D);
        do_write("w3.icw2", 1'b1, 8'h30);
        @(negedge clk);
        reset = 1'b1; write_enable = 1'b0; a0 = 1'b1; data_in = 8'h04;
        model_reset();
        sb.push_back(m);
        @(negedge clk);
        reset = 1'b0; write_enable = 1'b1;
        pop_compare("w3.reset");
        sb.push_back(m);
        @(negedge clk);
        pop_compare("w3.after");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
